decimal_scan_ctrl: RTL

- Scheduler that time-shares one external binary-to-decimal converter (7-bit in; tens/ones out; code 10 = blank digit) among four 7-bit display values.
- Background FSM converts all four channels once per frame into a double-buffered digit store.
- Scan engine independently multiplexes the resulting 8 digits onto a one-hot digit select and a 4-bit digit code for the 7-segment decoder.

---
 rtl/decimal_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/decimal_scan_ctrl.sv
// Time-shares one binary-to-decimal converter across four display channels and
// scans the resulting eight digits onto a one-hot select with a matching code.
module decimal_scan_ctrl #(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] val0,
  input  logic [6:0] val1,
  input  logic [6:0] val2,
  input  logic [6:0] val3,
  input  logic [3:0] lz,
  input  logic       freeze,
  output logic [6:0] conv_n,
  output logic       conv_lz,
  input  logic [3:0] conv_ten,
  input  logic [3:0] conv_one,
  output logic [7:0] digit_sel,
  output logic [3:0] digit_code,
  output logic [3:0] ovf,
  output logic       refresh_done
);

  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    BLANK     = 4'd10;
  localparam logic [6:0]    VAL_MAX   = 7'd99;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t        state, state_next;
  logic [1:0]    ch, ch_next;
  logic          start_pending;
  logic          commit;
  logic [6:0]    val_ch;

  logic [PW-1:0] presc;
  logic [2:0]    idx, idx_next;
  logic          scan_wrap, frame_start;

  logic [3:0]    shadow   [8];
  logic [3:0]    disp_buf [8];
  logic [3:0]    ovf_shadow;

  // ---------------------------------------------------------------- scan engine
  always_comb begin
    scan_wrap   = (presc == PRESC_MAX);
    idx_next    = scan_wrap ? idx + 3'd1 : idx;
    frame_start = scan_wrap && (idx == 3'd7);
  end

  // digit_code is looked up with the upcoming index so it changes on the same
  // edge as the select derived from idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      idx        <= '0;
      digit_code <= BLANK;
    end else begin
      presc      <= scan_wrap ? '0 : presc + PW'(1);
      idx        <= idx_next;
      digit_code <= disp_buf[idx_next];
    end
  end

  assign digit_sel = 8'b1 << idx;

  // ----------------------------------------------------------- conversion FSM
  always_comb begin
    case (ch)
      2'd0:    val_ch = val0;
      2'd1:    val_ch = val1;
      2'd2:    val_ch = val2;
      default: val_ch = val3;
    endcase
  end

  // NOTE: every output of this block is given a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    ch_next      = ch;
    conv_n       = '0;
    conv_lz      = 1'b0;
    refresh_done = 1'b0;
    commit       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_pending || frame_start) begin
          state_next = S_CONV;
          ch_next    = 2'd0;
        end
      end
      S_CONV: begin
        conv_n  = (val_ch > VAL_MAX) ? VAL_MAX : val_ch;
        conv_lz = lz[ch];
        if (ch == 2'd3) state_next = S_COMMIT;
        else            ch_next    = ch + 2'd1;
      end
      S_COMMIT: begin
        commit       = !freeze;
        refresh_done = !freeze;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the digit stores are reset explicitly because the display must come
  // up blank rather than showing whatever the flops power up with.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ch            <= '0;
      start_pending <= 1'b1;
      ovf_shadow    <= '0;
      ovf           <= '0;
      for (int i = 0; i < 8; i++) begin
        shadow[i]   <= BLANK;
        disp_buf[i] <= BLANK;
      end
    end else begin
      state         <= state_next;
      ch            <= ch_next;
      start_pending <= 1'b0;
      if (state == S_CONV) begin
        shadow[{ch, 1'b0}] <= conv_one;
        shadow[{ch, 1'b1}] <= conv_ten;
        ovf_shadow[ch]     <= (val_ch > VAL_MAX);
      end
      if (commit) begin
        disp_buf <= shadow;
        ovf      <= ovf_shadow;
      end
    end
  end

endmodule
